// File: rtl/mux_2x1.sv
// ----------------------------------------------------------------------------
// mux_2x1
//   Two-input selector used as the building block of the 4:1 tree.
//
// Parameters
//   WIDTH  bits per data input
//
// Ports
//   a  in   WIDTH  selected when s = 0
//   b  in   WIDTH  selected when s = 1
//   s  in   1      select
//   y  out  WIDTH  s ? b : a
// ----------------------------------------------------------------------------
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // NOTE: a continuous ternary assignment has no unassigned path, so it can
    // never infer a latch the way an incomplete if/case in always_comb can.
    assign y = s ? b : a;

endmodule

// File: rtl/mux_4x1.sv
// ----------------------------------------------------------------------------
// mux_4x1
//   4:1 lane selector built as a tree of three 2:1 muxes. Stage 1 picks
//   within each lane pair using sel[0]; stage 2 picks between the pairs using
//   sel[1]. The result is either driven straight out or registered once.
//
// Parameters
//   WIDTH    bits per lane; ip packs lane0 at the LSBs
//   REG_OUT  0 = combinational out, 1 = out registered on rising clk
//
// Ports
//   clk    in   1        clock (only used when REG_OUT = 1)
//   rst_n  in   1        asynchronous active-low reset (only when REG_OUT = 1)
//   ip     in   4*WIDTH  data lanes; lane k = ip[k*WIDTH +: WIDTH]
//   sel    in   2        binary lane select
//   out    out  WIDTH    selected lane
// ----------------------------------------------------------------------------
module mux_4x1 #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*WIDTH-1:0] ip,
    input  logic [1:0]         sel,
    output logic [WIDTH-1:0]   out
);

    localparam int SEL_W = 2;

    logic [SEL_W-1:0] sel_q;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] y;

    assign sel_q = sel;

    // Stage 1: choose within the low pair (lane0/lane1) and high pair (lane2/lane3).
    mux_2x1 #(.WIDTH(WIDTH)) u_lo (
        .a (ip[0*WIDTH +: WIDTH]),
        .b (ip[1*WIDTH +: WIDTH]),
        .s (sel_q[0]),
        .y (lo)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_hi (
        .a (ip[2*WIDTH +: WIDTH]),
        .b (ip[3*WIDTH +: WIDTH]),
        .s (sel_q[0]),
        .y (hi)
    );

    // Stage 2: choose between the pairs.
    mux_2x1 #(.WIDTH(WIDTH)) u_out (
        .a (lo),
        .b (hi),
        .s (sel_q[1]),
        .y (y)
    );

    generate
        if (REG_OUT) begin : g_reg
            // NOTE: sequential state is written with non-blocking assignments so
            // every flop samples its input before any flop updates at the edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out <= '0;
                end else begin
                    out <= y;
                end
            end
        end else begin : g_comb
            // Clock and reset have no load in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst_n};
            assign out = y;
        end
    endgenerate

endmodule

// File: tb/tb_mux_4x1.sv
// ----------------------------------------------------------------------------
// tb_mux_4x1
//   Self-checking bench for mux_4x1. Four instances cover the combinational
//   and registered builds at WIDTH = 1 and WIDTH = 8. Expected values come
//   from a shift-and-mask lane model, with the registered builds modelled as
//   "last value captured at an edge, or zero while in reset".
// ----------------------------------------------------------------------------
module tb_mux_4x1;

    logic        clk = 1'b0;
    logic        rst_n;

    // Combinational, WIDTH = 1
    logic [3:0]  ip_c1;
    logic [1:0]  sel_c1;
    logic        out_c1;
    // Combinational, WIDTH = 8
    logic [31:0] ip_c8;
    logic [1:0]  sel_c8;
    logic [7:0]  out_c8;
    // Registered, WIDTH = 1
    logic [3:0]  ip_r1;
    logic [1:0]  sel_r1;
    logic        out_r1;
    // Registered, WIDTH = 8
    logic [31:0] ip_r8;
    logic [1:0]  sel_r8;
    logic [7:0]  out_r8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_4x1 #(.WIDTH(1), .REG_OUT(1'b0)) u_dut_c1 (
        .clk (clk), .rst_n (rst_n), .ip (ip_c1), .sel (sel_c1), .out (out_c1)
    );
    mux_4x1 #(.WIDTH(8), .REG_OUT(1'b0)) u_dut_c8 (
        .clk (clk), .rst_n (rst_n), .ip (ip_c8), .sel (sel_c8), .out (out_c8)
    );
    mux_4x1 #(.WIDTH(1), .REG_OUT(1'b1)) u_dut_r1 (
        .clk (clk), .rst_n (rst_n), .ip (ip_r1), .sel (sel_r1), .out (out_r1)
    );
    mux_4x1 #(.WIDTH(8), .REG_OUT(1'b1)) u_dut_r8 (
        .clk (clk), .rst_n (rst_n), .ip (ip_r8), .sel (sel_r8), .out (out_r8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: lane s of a packed word with w-bit lanes.
    function automatic logic [31:0] lane_of(input logic [31:0] v, input int w, input int s);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >> (s * w)) & mask;
    endfunction

    logic [31:0] exp_r8;

    initial begin
        rst_n  = 1'b0;
        ip_c1  = '0; sel_c1 = '0;
        ip_c8  = '0; sel_c8 = '0;
        ip_r1  = '0; sel_r1 = '0;
        ip_r8  = '0; sel_r8 = '0;

        // ---------------- Registered builds held in reset ----------------
        #1;
        check("reset_r1", {31'd0, out_r1}, 32'd0);
        check("reset_r8", {24'd0, out_r8}, 32'd0);
        ip_r1  = 4'b1001; sel_r1 = 2'b11;
        ip_r8  = 32'hFFFF_FFFF; sel_r8 = 2'b10;
        @(posedge clk); #1;
        check("reset_hold_r1", {31'd0, out_r1}, 32'd0);
        check("reset_hold_r8", {24'd0, out_r8}, 32'd0);

        // ---------------- Directed combinational vectors ----------------
        begin
            logic [3:0] d_ip [4];
            logic [1:0] d_sel [4];
            logic       d_exp [4];
            d_ip[0] = 4'b0001; d_sel[0] = 2'b01; d_exp[0] = 1'b0;
            d_ip[1] = 4'b1001; d_sel[1] = 2'b11; d_exp[1] = 1'b1;
            d_ip[2] = 4'b0111; d_sel[2] = 2'b11; d_exp[2] = 1'b0;
            d_ip[3] = 4'b0110; d_sel[3] = 2'b01; d_exp[3] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                ip_c1 = d_ip[i]; sel_c1 = d_sel[i];
                #1;
                check($sformatf("directed_%0d", i), {31'd0, out_c1}, {31'd0, d_exp[i]});
            end
        end

        // ---------------- Exhaustive sweep, WIDTH = 1 ----------------
        for (int v = 0; v < 16; v++) begin
            for (int s = 0; s < 4; s++) begin
                ip_c1 = v[3:0]; sel_c1 = s[1:0];
                #1;
                check($sformatf("sweep_ip%0h_sel%0d", v, s), {31'd0, out_c1},
                      lane_of(32'(v), 1, s));
            end
        end

        // ---------------- Lane walk, WIDTH = 8 ----------------
        begin
            logic [7:0] walk_exp [4];
            walk_exp[0] = 8'hA1; walk_exp[1] = 8'hB2;
            walk_exp[2] = 8'hC3; walk_exp[3] = 8'hD4;
            ip_c8 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
            for (int s = 0; s < 4; s++) begin
                sel_c8 = s[1:0];
                #1;
                check($sformatf("walk_sel%0d", s), {24'd0, out_c8}, {24'd0, walk_exp[s]});
            end
        end

        // ---------------- Random combinational, simultaneous ip/sel change ----------------
        for (int i = 0; i < 60; i++) begin
            ip_c8  = $urandom;
            sel_c8 = 2'($urandom_range(0, 3));
            ip_c1  = 4'($urandom);
            sel_c1 = 2'($urandom_range(0, 3));
            #1;
            check("rand_c8", {24'd0, out_c8}, lane_of(ip_c8, 8, int'(sel_c8)));
            check("rand_c1", {31'd0, out_c1}, lane_of({28'd0, ip_c1}, 1, int'(sel_c1)));
        end

        // ---------------- Registered, WIDTH = 1: directed ----------------
        @(negedge clk);
        rst_n  = 1'b1;
        ip_r1  = 4'b1001; sel_r1 = 2'b11;
        ip_r8  = '0;      sel_r8 = 2'b00;
        #1;
        check("reg_before_edge", {31'd0, out_r1}, 32'd0);
        @(posedge clk); #1;
        check("reg_first_capture", {31'd0, out_r1}, 32'd1);
        #2;
        sel_r1 = 2'b01;
        #1;
        check("reg_sel_midcycle_hold", {31'd0, out_r1}, 32'd1);
        @(posedge clk); #1;
        check("reg_sel_after_edge", {31'd0, out_r1}, 32'd0);

        // Reset mid-operation, away from any clock edge.
        sel_r1 = 2'b11;
        @(posedge clk); #1;
        check("reg_before_midreset", {31'd0, out_r1}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reg_midreset_async", {31'd0, out_r1}, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("reg_release_hold", {31'd0, out_r1}, 32'd0);
        @(posedge clk); #1;
        check("reg_release_capture", {31'd0, out_r1}, 32'd1);

        // ---------------- Registered, WIDTH = 8: random with occasional reset ----------------
        exp_r8 = lane_of(ip_r8, 8, int'(sel_r8));
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ip_r8  = $urandom;
            sel_r8 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                // Pulse reset between edges; the register must clear at once.
                rst_n = 1'b0;
                #1;
                check("rand_r8_async_reset", {24'd0, out_r8}, 32'd0);
                rst_n = 1'b1;
                exp_r8 = 32'd0;
                #1;
                check("rand_r8_reset_hold", {24'd0, out_r8}, exp_r8);
            end else begin
                #1;
                check("rand_r8_hold", {24'd0, out_r8}, exp_r8);
            end
            @(posedge clk); #1;
            exp_r8 = lane_of(ip_r8, 8, int'(sel_r8));
            check("rand_r8_capture", {24'd0, out_r8}, exp_r8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
